// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared types, defaults and helpers for the SPI transfer scheduler
package spi_sched_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_LEN_W        = 4;
    localparam int DEF_CS_SETUP_CYC = 2;
    localparam int DEF_CS_HOLD_CYC  = 2;
    localparam int DEF_CS_GAP_CYC   = 1;
    localparam int MAX_REQ          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_BYTE_START,
        ST_BYTE_WAIT,
        ST_CS_HOLD,
        ST_CS_GAP
    } sched_state_e;

    // OR-reduction of set bit positions; exact only for one-hot inputs.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - round-robin winner search with registered pointer
module spi_rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [IDX_W-1:0]   win_idx,
    output logic [NUM_REQ-1:0] win_oh
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_hit;

    // Descending scan leaves the lowest set index at/after the pointer in hi_idx
    // and the lowest set index overall in lo_idx (used on wrap).
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr_q) begin
                    hi_idx = IDX_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        win_idx = hi_hit ? hi_idx : lo_idx;
        win_oh  = NUM_REQ'(1) << win_idx;
        ptr_d   = ptr_q;
        if (update) begin
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// rtl/spi_xfer_sched.sv - arbitrates requesters onto one SPI byte engine with CS timing
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
    parameter int CS_GAP_CYC   = DEF_CS_GAP_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     tx_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     tx_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    output logic                     xfer_done,
    output logic                     busy,
    output logic                     eng_start,
    output logic [7:0]               eng_tx,
    input  logic                     eng_done,
    input  logic [7:0]               eng_rx,
    output logic [NUM_REQ-1:0]       spi_cs_n
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD_CYC - 1);
    localparam logic [7:0] GAP_LD   = 8'(CS_GAP_CYC - 1);

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tmr_q, tmr_d;
    logic               eng_start_q, eng_start_d;
    logic [7:0]         eng_tx_q, eng_tx_d;
    logic               tx_ready_q, tx_ready_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               xfer_done_q, xfer_done_d;

    logic               arb_update;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   cur_idx;
    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic [7:0]         tx_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
        assign tx_arr[g]  = tx_data[g*8 +: 8];
    end

    assign cur_idx = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_q)));

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .update  (arb_update),
        .win_idx (win_idx),
        .win_oh  (win_oh)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        eng_start_d = 1'b0;
        eng_tx_d    = eng_tx_q;
        tx_ready_d  = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        xfer_done_d = 1'b0;
        arb_update  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d      = win_oh;
                    cnt_d      = len_arr[win_idx];
                    tmr_d      = SETUP_LD;
                    arb_update = 1'b1;
                    state_d    = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (tmr_q == '0) state_d = ST_BYTE_START;
                else             tmr_d   = tmr_q - 8'd1;
            end
            ST_BYTE_START: begin
                eng_start_d = 1'b1;
                eng_tx_d    = tx_arr[cur_idx];
                tx_ready_d  = 1'b1;
                state_d     = ST_BYTE_WAIT;
            end
            ST_BYTE_WAIT: begin
                if (eng_done) begin
                    rx_data_d  = eng_rx;
                    rx_valid_d = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = ST_BYTE_START;
                    end else begin
                        tmr_d   = HOLD_LD;
                        state_d = ST_CS_HOLD;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tmr_q == '0) begin
                    gnt_d       = '0;
                    xfer_done_d = 1'b1;
                    tmr_d       = GAP_LD;
                    state_d     = ST_CS_GAP;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_CS_GAP: begin
                if (tmr_q == '0) state_d = ST_IDLE;
                else             tmr_d   = tmr_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            eng_start_q <= 1'b0;
            eng_tx_q    <= 8'h00;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            eng_start_q <= eng_start_d;
            eng_tx_q    <= eng_tx_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    // Chip-selects derive from the grant register so they can never disagree.
    assign gnt       = gnt_q;
    assign spi_cs_n  = ~gnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign eng_start = eng_start_q;
    assign eng_tx    = eng_tx_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign xfer_done = xfer_done_q;

endmodule

// File: doc/spi_xfer_sched.md
Name: spi_xfer_sched

Overview:
- Sequences a single shared SPI byte engine (shifter driving spi_sclk/spi_mosi/spi_miso) among NUM_REQ requesters.
- Round-robin arbitrates, owns one chip-select per requester with programmable setup/hold/gap timing, and streams multi-byte transactions through the engine's start/done handshake.
- Sits between on-chip clients and the SPI byte engine; slaves such as the loopback test slave hang off spi_cs_n.

Parameters:
- NUM_REQ, 4, number of requesters and chip-selects (2..8)
- LEN_W, 4, width of the per-requester length field; transaction length = req_len+1 bytes (1..2^LEN_W)
- CS_SETUP_CYC, 2, clk cycles from CS assert to first eng_start (>=1)
- CS_HOLD_CYC, 2, clk cycles from last eng_done to CS deassert (>=1)
- CS_GAP_CYC, 1, minimum CS-high cycles before the next grant (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester transaction request, level
- req_len  in  NUM_REQ*LEN_W  per-requester bytes-1, slice i = requester i
- tx_data  in  NUM_REQ*8  per-requester next byte to send
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- tx_ready  out  1  pulse: the granted requester's tx_data byte was consumed
- rx_data  out  8  byte received from the engine
- rx_valid  out  1  pulse: rx_data is valid for the granted requester
- xfer_done  out  1  pulse: the granted transaction has completed
- busy  out  1  high in any state other than IDLE
- eng_start  out  1  pulse: engine starts one byte
- eng_tx  out  8  byte for the engine, valid with eng_start
- eng_done  in  1  pulse: engine finished a byte
- eng_rx  in  8  received byte, valid with eng_done
- spi_cs_n  out  NUM_REQ  active-low chip-selects

Behaviour:
- Reset (async, rst_n=0):
  - spi_cs_n all 1; gnt, eng_start, tx_ready, rx_valid, xfer_done and busy all 0; eng_tx and rx_data 8'h00.
  - Round-robin pointer = 0; state = IDLE.
  - Reset mid-transaction aborts immediately with no xfer_done.
- States: IDLE, CS_SETUP, BYTE_START, BYTE_WAIT, CS_HOLD, CS_GAP.
- IDLE: when req is nonzero, select the first set bit at or after the pointer, wrapping modulo NUM_REQ. On the next edge:
  - gnt = one-hot winner; that winner's spi_cs_n = 0
  - remaining-byte counter = req_len[winner]
  - pointer = winner+1 (mod NUM_REQ)
  - setup counter loaded; state -> CS_SETUP
- CS_SETUP: stays exactly CS_SETUP_CYC cycles, then -> BYTE_START.
- BYTE_START: one cycle.
  - eng_start=1, eng_tx=tx_data[winner], tx_ready=1 (registered outputs).
  - -> BYTE_WAIT.
- BYTE_WAIT: waits for eng_done.
  - On eng_done, register eng_rx into rx_data; rx_valid=1 the next cycle.
  - If counter != 0: decrement and go -> BYTE_START.
  - Otherwise -> CS_HOLD.
- CS_HOLD: stays CS_HOLD_CYC cycles. On exit, in the same edge:
  - spi_cs_n all 1, gnt=0, xfer_done=1 for one cycle
  - state -> CS_GAP
- CS_GAP: stays CS_GAP_CYC cycles, then -> IDLE. Requests are not evaluated here.
- Latency: first eng_start occurs CS_SETUP_CYC+1 cycles after the grant edge.
- Requester contract: hold req, req_len and tx_data stable until tx_ready; present the next byte in the cycle after tx_ready.
  - req_len is sampled only at grant.
  - Deasserting req mid-transaction is ignored; the transaction completes at its latched length.
- eng_done outside BYTE_WAIT is ignored; no error flag.
- At most one spi_cs_n bit is low at any time. gnt equals ~spi_cs_n in every cycle.
- Simultaneous requests: the round-robin choice is the only tie-break. A requester re-asserting immediately loses to any other pending requester.
- The counter is LEN_W bits; req_len all-ones yields 2^LEN_W bytes with no overflow.

Decomposition:
- Package spi_sched_pkg holds:
  - the state enum
  - default parameter constants (NUM_REQ, LEN_W, timing defaults)
  - a function for the one-hot-to-index conversion
- Sub-module spi_rr_arbiter holds the combinational winner search plus the registered pointer, with inputs req/update and outputs winner index/one-hot.
- Counters and the FSM stay in spi_xfer_sched.

Test Plan:
- Single 1-byte transfer: req[0]=1, req_len=0, tx_data=8'hA5, engine returns 8'h3C after 16 cycles.
  - cs_n[0] falls at grant.
  - eng_start 3 cycles later with eng_tx=A5.
  - rx_valid with rx_data=3C.
  - cs_n[0] rises and xfer_done pulses CS_HOLD_CYC cycles after eng_done.
- 3-byte burst on requester 2 (bytes 11,22,33) against an engine model that returns the received byte +1: rx sequence is 12,23,34.
  - Exactly 3 tx_ready pulses.
  - cs_n[2] stays low continuously.
- Round-robin: req=4'b1111 held.
  - Grant order is 0,1,2,3,0.
  - Each grant is separated by at least CS_GAP_CYC cycles with all cs_n high.
- Max length: req_len=4'hF.
  - Exactly 16 eng_start pulses, then xfer_done.
  - No counter wrap to a 17th byte.
- Reset mid-transaction: drop rst_n during the second BYTE_WAIT of a 4-byte transfer.
  - All cs_n go high asynchronously; gnt and busy go to 0.
  - No xfer_done pulse.
  - After release, the next grant goes to requester 0.
- Spurious eng_done pulsed in IDLE and CS_SETUP: no rx_valid, and no state change.
